transmitter: RTL and testbench

TRANSMITTER -- requirements
Module: transmitter

---
 rtl/transmitter.sv | 124 ++++++++++++
 tb/tb_transmitter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/transmitter.sv
// rtl/transmitter.sv - framed serial transmitter: SYNC marker, MSB-first words on dClk, then a gap
module transmitter #(
    parameter int HALF        = 4,
    parameter int FRAME_WORDS = 8
) (
    input  logic        cClk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] wordIn,
    input  logic        wValid,
    output logic        wAck,
    output logic        dClk,
    output logic        data,
    output logic        sync,
    output logic        underrun,
    output logic        frameDone
);

    localparam int DW = $clog2(HALF);
    localparam int WW = $clog2(FRAME_WORDS + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(HALF - 1);
    localparam logic [DW-1:0] DIV_PRE   = DW'(HALF - 2);
    localparam logic [WW-1:0] WORDS_ALL = WW'(FRAME_WORDS);

    typedef enum logic [1:0] {IDLE, SYNC, SHIFT, GAP} state_t;

    state_t        state;
    logic [DW-1:0] divCnt;
    logic          phase;
    logic [3:0]    bitCnt;
    logic [WW-1:0] wordCnt;
    logic [15:0]   shiftReg;

    logic halfEnd;
    logic periodEnd;
    logic loadNow;

    // phase=0 is the dClk-high half of a period, phase=1 the low half
    assign halfEnd   = (divCnt == DIV_LAST);
    assign periodEnd = halfEnd && phase;
    assign loadNow   = periodEnd && ((state == SYNC) ||
                       (state == SHIFT && bitCnt == 4'd0 && wordCnt != WORDS_ALL));

    always_ff @(posedge cClk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            divCnt    <= '0;
            phase     <= 1'b0;
            bitCnt    <= '0;
            wordCnt   <= '0;
            shiftReg  <= '0;
            wAck      <= 1'b0;
            dClk      <= 1'b0;
            data      <= 1'b0;
            sync      <= 1'b0;
            underrun  <= 1'b0;
            frameDone <= 1'b0;
        end else begin
            wAck      <= 1'b0;
            underrun  <= 1'b0;
            frameDone <= 1'b0;
            if (state != IDLE) begin
                divCnt <= halfEnd ? '0 : divCnt + 1'b1;
                if (halfEnd) phase <= ~phase;
            end
            case (state)
                IDLE: begin
                    if (enable) begin
                        state   <= SYNC;
                        sync    <= 1'b1;
                        divCnt  <= '0;
                        phase   <= 1'b0;
                        wordCnt <= '0;
                    end
                end
                SYNC: begin
                    if (periodEnd) begin
                        state <= SHIFT;
                        sync  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (halfEnd && !phase) begin
                        dClk <= 1'b0;
                    end else if (periodEnd) begin
                        if (bitCnt != 4'd0) begin
                            bitCnt   <= bitCnt - 4'd1;
                            shiftReg <= shiftReg << 1;
                            data     <= shiftReg[14];
                            dClk     <= 1'b1;
                        end else if (wordCnt == WORDS_ALL) begin
                            state <= GAP;
                            data  <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    frameDone <= phase && (divCnt == DIV_PRE);
                    if (periodEnd) begin
                        if (enable) begin
                            state   <= SYNC;
                            sync    <= 1'b1;
                            wordCnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // Word load starts bit 15; a missing word is replaced by zeros
            if (loadNow) begin
                shiftReg <= wValid ? wordIn : 16'h0000;
                data     <= wValid & wordIn[15];
                dClk     <= 1'b1;
                bitCnt   <= 4'd15;
                wordCnt  <= wordCnt + 1'b1;
                wAck     <= wValid;
                underrun <= ~wValid;
            end
        end
    end

endmodule

// File: tb/tb_transmitter.sv
// tb/tb_transmitter.sv - randomized self-checking bench for transmitter against a frame-level model
module tb_transmitter;

    localparam int HALF = 4;
    localparam int FW   = 2;
    localparam int PER  = 2 * HALF;
    localparam int FLEN = PER * (2 + 16 * FW);

    logic        cClk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] wordIn = 16'h0;
    logic        wValid = 1'b0;
    logic        wAck, dClk, data, sync, underrun, frameDone;

    int total = 0;
    int bad   = 0;

    logic [15:0] words [0:15];
    logic        valids[0:15];
    int          feedIdx;
    logic [5:0]  obs[$];

    transmitter #(.HALF(HALF), .FRAME_WORDS(FW)) dut (
        .cClk(cClk), .reset(reset), .enable(enable), .wordIn(wordIn), .wValid(wValid),
        .wAck(wAck), .dClk(dClk), .data(data), .sync(sync), .underrun(underrun),
        .frameDone(frameDone)
    );

    always #5 cClk = ~cClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {dClk, data, sync, wAck, underrun, frameDone};
    endfunction

    task automatic present();
        if (feedIdx < 16) begin
            wValid = valids[feedIdx];
            wordIn = valids[feedIdx] ? words[feedIdx] : 16'($urandom);
        end else begin
            wValid = 1'b0;
            wordIn = 16'h0;
        end
    endtask

    task automatic step();
        @(posedge cClk);
        #1;
        obs.push_back(outs());
        if (wAck || underrun) begin
            feedIdx++;
            present();
        end
    endtask

    task automatic newWords();
        for (int i = 0; i < 16; i++) begin
            words[i]  = 16'($urandom);
            valids[i] = 1'b1;
        end
    endtask

    // Expected outputs {dClk,data,sync,wAck,underrun,frameDone} at cycle c after enable is sampled
    function automatic logic [5:0] expVec(input int c, input int nFrames);
        int f, r, k, ph, w;
        logic b, first;
        f = c / FLEN;
        r = c % FLEN;
        if (f >= nFrames) return 6'b000000;
        if (r < PER) return 6'b001000;
        if (r < PER + 16 * FW * PER) begin
            k     = (r - PER) / PER;
            ph    = (r - PER) % PER;
            w     = f * FW + k / 16;
            b     = words[w][15 - (k % 16)] & valids[w];
            first = (ph == 0) && (k % 16 == 0);
            return {(ph < HALF), b, 1'b0, first & valids[w], first & ~valids[w], 1'b0};
        end
        return {5'b00000, (r == FLEN - 1)};
    endfunction

    function automatic int countBit(input int b);
        int n = 0;
        foreach (obs[i]) if (obs[i][b]) n++;
        return n;
    endfunction

    task automatic runFrames(input string tag, input int nFrames, input int dropAt, input int extra);
        int nBad, firstBad;
        obs.delete();
        feedIdx = 0;
        present();
        enable = 1'b1;
        for (int c = 0; c < nFrames * FLEN + extra; c++) begin
            if (c == dropAt) enable = 1'b0;
            step();
        end
        enable = 1'b0;
        nBad = 0;
        firstBad = -1;
        foreach (obs[c]) begin
            if (obs[c] !== expVec(c, nFrames)) begin
                nBad++;
                if (firstBad < 0) firstBad = c;
            end
        end
        check({tag, " mismatched cycles"}, 32'(nBad), 32'd0);
        if (firstBad >= 0)
            check({tag, " first bad cycle outputs"}, 32'(obs[firstBad]), 32'(expVec(firstBad, nFrames)));
    endtask

    initial begin
        int spacingBad, lastDone, nDone;
        logic [31:0] stream;

        newWords();
        feedIdx = 0;
        present();

        // Reset state
        for (int i = 0; i < 3; i++) step();
        check("reset outputs", 32'(outs()), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("idle outputs", 32'(outs()), 32'd0);

        // Directed frame A5C3, 0FF0 with a one-cycle enable pulse
        newWords();
        words[0] = 16'hA5C3;
        words[1] = 16'h0FF0;
        runFrames("basic", 1, 1, 30);
        stream = '0;
        foreach (obs[c]) begin
            if (obs[c][5] && (c == 0 || !obs[c-1][5])) stream = {stream[30:0], obs[c][4]};
        end
        check("basic bitstream", stream, 32'hA5C30FF0);
        check("basic wAck count", 32'(countBit(2)), 32'd2);
        check("basic frameDone count", 32'(countBit(0)), 32'd1);
        check("basic sync cycles", 32'(countBit(3)), 32'(PER));

        // Underrun on word 1
        newWords();
        valids[1] = 1'b0;
        runFrames("underrun", 1, 1, 30);
        check("underrun pulses", 32'(countBit(1)), 32'd1);
        check("underrun wAck count", 32'(countBit(2)), 32'd1);

        // Three back-to-back frames, random gaps in supply, enable dropped mid-SHIFT of frame 3
        newWords();
        for (int i = 0; i < 3 * FW; i++) valids[i] = ($urandom_range(0, 4) != 0);
        runFrames("three frames", 3, 2 * FLEN + 100, 40);
        nDone = 0;
        lastDone = -1;
        spacingBad = 0;
        foreach (obs[c]) begin
            if (obs[c][0]) begin
                if (lastDone >= 0 && c - lastDone != FLEN) spacingBad++;
                lastDone = c;
                nDone++;
            end
        end
        check("three frames frameDone count", 32'(nDone), 32'd3);
        check("three frames frameDone spacing errors", 32'(spacingBad), 32'd0);

        // Reset at bit 7 of word 0, then a fresh frame
        newWords();
        obs.delete();
        feedIdx = 0;
        present();
        enable = 1'b1;
        for (int c = 0; c < PER + 8 * PER + 3; c++) step();
        check("pre-reset dClk high in bit 7", 32'(dClk), 32'd1);
        reset = 1'b0;
        #1;
        check("async reset outputs", 32'(outs()), 32'd0);
        obs.delete();
        for (int i = 0; i < 10; i++) step();
        check("held reset wAck/sync/dClk activity", 32'(countBit(5) + countBit(3) + countBit(2)), 32'd0);
        reset = 1'b1;
        newWords();
        runFrames("after reset", 1, 100, 30);
        check("after reset sync cycles", 32'(countBit(3)), 32'(PER));
        check("after reset first wAck cycle", 32'(obs[PER][2]), 32'd1);

        // Enable dropped mid-SHIFT: single frame then idle
        newWords();
        runFrames("drop mid shift", 1, PER + 20 * PER, 60);
        check("drop mid shift frameDone count", 32'(countBit(0)), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
